// File: rtl/rv32i_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_decode_stage
// Desc     : RV32I decode stage; registered output plus one-entry skid buffer.
//            Optional illegal-encoding detection: DECODE_ILLEGAL_CHECK_EN
// Revision : 1.0 - initial release
// ============================================================================

module rv32i_decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [3:0]      out_alu_op,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [XLEN-1:0] out_imm,
  output logic            out_reg_write,
  output logic            out_use_imm,
  output logic            out_illegal
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam logic [6:0] c_opc_lui    = 7'b0110111;
  localparam logic [6:0] c_opc_auipc  = 7'b0010111;
  localparam logic [6:0] c_opc_jal    = 7'b1101111;
  localparam logic [6:0] c_opc_jalr   = 7'b1100111;
  localparam logic [6:0] c_opc_branch = 7'b1100011;
  localparam logic [6:0] c_opc_load   = 7'b0000011;
  localparam logic [6:0] c_opc_store  = 7'b0100011;
  localparam logic [6:0] c_opc_op_imm = 7'b0010011;
  localparam logic [6:0] c_opc_op     = 7'b0110011;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    alu_op_e         alu_op;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic            reg_write;
    logic            use_imm;
    logic            illegal;
  } bundle_t;

  // SUB exists only in R-type: addi with a negative immediate also has bit 30 set.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] f3,
                                              input logic       bit30,
                                              input logic       is_rtype);
    alu_op_e op;
    op = ALU_ADD;
    case (f3)
      3'b000:  op = (is_rtype && bit30) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = bit30 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic [31:0] w_imm_shamt;
  logic        w_illegal;
  logic        w_accept;
  bundle_t     w_dec;

  assign w_opcode    = in_instr[6:0];
  assign w_funct3    = in_instr[14:12];
  assign w_imm_i     = {{20{in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s     = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign w_imm_b     = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                        in_instr[30:25], in_instr[11:8], 1'b0};
  assign w_imm_u     = {in_instr[31:12], 12'b0};
  assign w_imm_j     = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                        in_instr[20], in_instr[30:21], 1'b0};
  assign w_imm_shamt = {27'b0, in_instr[24:20]};

`ifdef DECODE_ILLEGAL_CHECK_EN
  logic [6:0] w_funct7;
  assign w_funct7 = in_instr[31:25];

  always_comb begin : p_illegal
    w_illegal = 1'b0;
    case (w_opcode)
      c_opc_op:
        w_illegal = !((w_funct7 == 7'h00) ||
                      ((w_funct7 == 7'h20) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));
      c_opc_op_imm: begin
        if (w_funct3 == 3'b001) begin
          w_illegal = (w_funct7 != 7'h00);
        end else if (w_funct3 == 3'b101) begin
          w_illegal = (w_funct7 != 7'h00) && (w_funct7 != 7'h20);
        end
      end
      c_opc_load:   w_illegal = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111);
      c_opc_store:  w_illegal = (w_funct3 >= 3'b011);
      c_opc_branch: w_illegal = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
      c_opc_jalr:   w_illegal = (w_funct3 != 3'b000);
      c_opc_lui, c_opc_auipc, c_opc_jal: w_illegal = 1'b0;
      default:      w_illegal = 1'b1;
    endcase
  end
`else
  assign w_illegal = 1'b0;
`endif

  always_comb begin : p_decode
    w_dec           = '0;
    w_dec.pc        = in_pc;
    w_dec.opcode    = w_opcode;
    w_dec.rd        = in_instr[11:7];
    w_dec.rs1       = in_instr[19:15];
    w_dec.rs2       = in_instr[24:20];
    w_dec.funct3    = w_funct3;
    w_dec.alu_op    = ALU_ADD;
    case (w_opcode)
      c_opc_op: begin
        w_dec.alu_op    = alu_from_funct3(w_funct3, in_instr[30], 1'b1);
        w_dec.reg_write = 1'b1;
      end
      c_opc_op_imm: begin
        w_dec.alu_op    = alu_from_funct3(w_funct3, in_instr[30], 1'b0);
        w_dec.imm       = (w_funct3 == 3'b001 || w_funct3 == 3'b101) ? w_imm_shamt : w_imm_i;
        w_dec.reg_write = 1'b1;
        w_dec.use_imm   = 1'b1;
      end
      c_opc_load: begin
        w_dec.imm       = w_imm_i;
        w_dec.reg_write = 1'b1;
        w_dec.use_imm   = 1'b1;
      end
      c_opc_store: begin
        w_dec.imm     = w_imm_s;
        w_dec.use_imm = 1'b1;
      end
      c_opc_branch: begin
        w_dec.alu_op = ALU_SUB;
        w_dec.imm    = w_imm_b;
      end
      c_opc_jal: begin
        w_dec.imm       = w_imm_j;
        w_dec.reg_write = 1'b1;
      end
      c_opc_jalr: begin
        w_dec.imm       = w_imm_i;
        w_dec.reg_write = 1'b1;
        w_dec.use_imm   = 1'b1;
      end
      c_opc_lui, c_opc_auipc: begin
        w_dec.imm       = w_imm_u;
        w_dec.reg_write = 1'b1;
        w_dec.use_imm   = 1'b1;
      end
      default: begin
        w_dec.alu_op = alu_from_funct3(w_funct3, in_instr[30], 1'b0);
      end
    endcase
    w_dec.illegal = w_illegal;
    if (w_illegal) begin
      w_dec.reg_write = 1'b0;
    end
  end

  bundle_t out_q, out_d;
  bundle_t skid_q, skid_d;
  logic    out_valid_q, out_valid_d;
  logic    skid_full_q, skid_full_d;

  // in_ready depends only on skid occupancy, so out_ready never reaches fetch combinationally.
  assign w_accept = in_valid && !skid_full_q;

  always_comb begin : p_next
    out_d       = out_q;
    skid_d      = skid_q;
    out_valid_d = out_valid_q;
    skid_full_d = skid_full_q;
    if (flush) begin
      out_valid_d = 1'b0;
      skid_full_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_full_q) begin
        out_d       = skid_q;
        out_valid_d = 1'b1;
        skid_full_d = 1'b0;
      end else if (w_accept) begin
        out_d       = w_dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (w_accept) begin
      skid_d      = w_dec;
      skid_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin : p_regs
    if (rst) begin
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      skid_full_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      skid_full_q <= skid_full_d;
    end
  end

  assign in_ready      = !skid_full_q;
  assign out_valid     = out_valid_q;
  assign out_pc        = out_q.pc;
  assign out_opcode    = out_q.opcode;
  assign out_alu_op    = out_q.alu_op;
  assign out_rd        = out_q.rd;
  assign out_rs1       = out_q.rs1;
  assign out_rs2       = out_q.rs2;
  assign out_funct3    = out_q.funct3;
  assign out_imm       = out_q.imm;
  assign out_reg_write = out_q.reg_write;
  assign out_use_imm   = out_q.use_imm;
  assign out_illegal   = out_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_rv32i_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_decode_stage
// Desc     : Self-checking bench for rv32i_decode_stage (vector table + scoreboard)
// Revision : 1.0 - initial release
// ============================================================================

module tb_rv32i_decode_stage;

`ifdef DECODE_ILLEGAL_CHECK_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [6:0]  out_opcode;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;
  logic        out_reg_write, out_use_imm, out_illegal;

  always #5 clk = ~clk;

  rv32i_decode_stage #(.XLEN(32), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_alu_op(out_alu_op),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_imm(out_imm),
    .out_reg_write(out_reg_write), .out_use_imm(out_use_imm), .out_illegal(out_illegal)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic        rw;
    logic        ui;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] instr;
    exp_t        e;
  } vec_t;

  vec_t vt[$];
  exp_t q[$];
  exp_t drv_exp;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   rand_done;

  task automatic add(input logic [31:0] instr, input logic [6:0] op, input logic [3:0] alu,
                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [2:0] f3, input logic [31:0] imm,
                     input logic rw, input logic ui, input logic ill);
    vec_t v;
    v.instr    = instr;
    v.e.pc     = 32'h1000 + 32'(vt.size() * 4);
    v.e.opcode = op;
    v.e.alu    = alu;
    v.e.rd     = rd;
    v.e.rs1    = rs1;
    v.e.rs2    = rs2;
    v.e.f3     = f3;
    v.e.imm    = imm;
    v.e.ui     = ui;
    v.e.ill    = ill && ILL_EN;
    v.e.rw     = rw && !(ill && ILL_EN);
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic set_in(input int idx);
    in_valid = 1'b1;
    in_instr = vt[idx].instr;
    in_pc    = vt[idx].e.pc;
    drv_exp  = vt[idx].e;
  endtask

  // Holds the offer until the handshake edge; returns #1 after that edge.
  task automatic offer(input int idx, input int budget);
    bit acc;
    set_in(idx);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      acc = in_ready && !flush && !rst;
      @(posedge clk);
      #1;
      if (acc) return;
    end
    n_vec++;
    n_bad++;
    $display("FAIL offer_timeout: vector %0d not accepted within %0d cycles", idx, budget);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    exp_t g;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 || flush === 1'b1) begin
        q.delete();
      end else begin
        if (out_valid === 1'b1) begin
          g = {out_pc, out_opcode, out_alu_op, out_rd, out_rs1, out_rs2, out_funct3,
               out_imm, out_reg_write, out_use_imm, out_illegal};
          n_vec++;
          if (q.size() == 0) begin
            n_bad++;
            $display("FAIL out_unexpected: got pc %h, expected no output", out_pc);
          end else begin
            if (g !== q[0]) begin
              n_bad++;
              $display("FAIL out_bundle: got %h expected %h", g, q[0]);
            end
            if (out_ready === 1'b1) void'(q.pop_front());
          end
        end
        if (in_valid === 1'b1 && in_ready === 1'b1) q.push_back(drv_exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    out_ready = 1'b0; drv_exp = '0; rand_done = 1'b0;

    //   instr         op     alu  rd  rs1 rs2 f3  imm           rw ui ill
    add(32'h002081B3, 7'h33, 0,  3,  1,  2,  0, 32'h00000000, 1, 0, 0); // add
    add(32'h402081B3, 7'h33, 1,  3,  1,  2,  0, 32'h00000000, 1, 0, 0); // sub
    add(32'hFFF00093, 7'h13, 0,  1,  0, 31,  0, 32'hFFFFFFFF, 1, 1, 0); // addi -1
    add(32'hFE000EE3, 7'h63, 1, 29,  0,  0,  0, 32'hFFFFFFFC, 0, 0, 0); // beq -4
    add(32'h00812283, 7'h03, 0,  5,  2,  8,  2, 32'h00000008, 1, 1, 0); // lw
    add(32'hFE612C23, 7'h23, 0, 24,  2,  6,  2, 32'hFFFFFFF8, 0, 1, 0); // sw -8
    add(32'h123453B7, 7'h37, 0,  7,  8,  3,  5, 32'h12345000, 1, 1, 0); // lui
    add(32'hFFFFF417, 7'h17, 0,  8, 31, 31,  7, 32'hFFFFF000, 1, 1, 0); // auipc
    add(32'hFF9FF0EF, 7'h6F, 0,  1, 31, 25,  7, 32'hFFFFFFF8, 1, 0, 0); // jal -8
    add(32'h00008067, 7'h67, 0,  0,  1,  0,  0, 32'h00000000, 1, 1, 0); // jalr
    add(32'h4032D213, 7'h13, 7,  4,  5,  3,  5, 32'h00000003, 1, 1, 0); // srai
    add(32'h01F51493, 7'h13, 2,  9, 10, 31,  1, 32'h0000001F, 1, 1, 0); // slli 31
    add(32'h00C5F533, 7'h33, 9, 10, 11, 12,  7, 32'h00000000, 1, 0, 0); // and
    add(32'h0020E863, 7'h63, 1, 16,  1,  2,  6, 32'h00000010, 0, 0, 0); // bltu +16
    add(32'h8001B113, 7'h13, 4,  2,  3,  0,  3, 32'hFFFFF800, 1, 1, 0); // sltiu -2048
    add(32'h403150B3, 7'h33, 7,  1,  2,  3,  5, 32'h00000000, 1, 0, 0); // sra
    add(32'h0000007F, 7'h7F, 0,  0,  0,  0,  0, 32'h00000000, 0, 0, 1); // unknown

    fork
      monitor();
    join_none

    // Reset state
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_alu_op", 32'(out_alu_op), 32'd0);
    chk("rst_imm", out_imm, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_reg_write", 32'(out_reg_write), 32'd0);

    // Streaming with no back-pressure, one-cycle latency
    @(posedge clk); #1;
    out_ready = 1'b1;
    offer(0, 10);
    in_valid = 1'b0;
    chk("latency_out_valid", 32'(out_valid), 32'd1);
    chk("latency_out_rd", 32'(out_rd), 32'd3);
    for (int i = 1; i < vt.size(); i++) offer(i, 10);
    in_valid = 1'b0;
    idle(4);

    // Back-pressure: two accepted, third blocked until release
    out_ready = 1'b0;
    offer(2, 10);
    offer(3, 10);
    set_in(4);
    @(negedge clk);
    chk("bp_in_ready_drop", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready_hold", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    offer(4, 10);
    in_valid = 1'b0;
    idle(5);
    chk("bp_drained", 32'(q.size()), 32'd0);

    // Flush with output and skid full and a concurrent offer
    out_ready = 1'b0;
    offer(5, 10);
    offer(6, 10);
    set_in(7);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("flush_no_ghost", 32'(out_valid), 32'd0);
    end

    // Random back-pressure over the whole table
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < vt.size(); i++) offer(i, 50);
        in_valid = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    for (int n = 0; n < 50 && q.size() != 0; n++) idle(1);
    idle(2);
    chk("rand_drained", 32'(q.size()), 32'd0);

    // Reset in the middle of a stall
    out_ready = 1'b0;
    offer(8, 10);
    offer(9, 10);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_alu_op", 32'(out_alu_op), 32'd0);
    chk("midrst_imm", out_imm, 32'd0);
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_ghost", 32'(out_valid), 32'd0);
    end

    // Unknown opcode
    @(posedge clk); #1;
    offer(16, 10);
    in_valid = 1'b0;
    chk("illegal_flag", 32'(out_illegal), 32'(ILL_EN));
    chk("illegal_reg_write", 32'(out_reg_write), 32'd0);
    idle(3);
    chk("final_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
